// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result bus between a controller and the serial subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (output start, a, b, input busy, done, d, bout, ovf);
  modport slave  (input start, a, b, output busy, done, d, bout, ovf);

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: diff = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor d = a - b, LSB first, one bit per clock
// through a single full-subtractor cell with a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             diff_s;
  logic             bnext_s;

  full_subtractor u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (borrow_q),
    .diff (diff_s),
    .bout (bnext_s)
  );

  // Next-state logic: FSM, counter, operand/result shifters and result capture.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dout_d   = dout_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          sa_d     = bus.a;
          sb_d     = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          sign_a_d = bus.a[WIDTH-1];
          sign_b_d = bus.b[WIDTH-1];
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        res_d    = {diff_s, res_q[WIDTH-1:1]};
        borrow_d = bnext_s;
        if (cnt_q == CNT_LAST) begin
          // Publish the result on the last bit so it is valid alongside done.
          state_d = S_DONE;
          dout_d  = {diff_s, res_q[WIDTH-1:1]};
          bout_d  = bnext_s;
          ovf_d   = (sign_a_q != sign_b_q) && (diff_s != sign_a_q);
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = dout_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  logic [7:0] va [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
  logic [7:0] vb [5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
  logic [7:0] vd [5] = '{8'h02, 8'hFE, 8'h00, 8'h7F, 8'h80};
  logic       vbo[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       vov[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // edges counts the acceptance edge as 1; returns when done is seen or the budget runs out
  task automatic wait_done8(output int edges, output int busy_cycles);
    edges = 1;
    busy_cycles = 0;
    while (!bus8.done && edges < 40) begin
      if (bus8.busy) busy_cycles++;
      tick();
      edges++;
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, output int lat, output int bc);
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    wait_done8(lat, bc);
  endtask

  task automatic run_op16(input logic [15:0] a, input logic [15:0] b, output int lat);
    bus16.a = a;
    bus16.b = b;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    lat = 1;
    while (!bus16.done && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({bus8.busy, bus8.done, bus8.d, bus8.bout, bus8.ovf} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset8: got busy=%b done=%b d=%h bout=%b ovf=%b, expected all 0",
               bus8.busy, bus8.done, bus8.d, bus8.bout, bus8.ovf);
    end
    n_cmp++;
    if ({bus16.busy, bus16.done, bus16.d, bus16.bout, bus16.ovf} !== 20'h00000) begin
      n_bad++;
      $display("FAIL reset16: got busy=%b done=%b d=%h, expected all 0",
               bus16.busy, bus16.done, bus16.d);
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      run_op8(va[i], vb[i], lat, bc);
      n_cmp++;
      if ({bus8.d, bus8.bout, bus8.ovf} !== {vd[i], vbo[i], vov[i]}) begin
        n_bad++;
        $display("FAIL directed[%0d] %h-%h: got d=%h bout=%b ovf=%b, expected d=%h bout=%b ovf=%b",
                 i, va[i], vb[i], bus8.d, bus8.bout, bus8.ovf, vd[i], vbo[i], vov[i]);
      end
      n_cmp++;
      if (lat !== 9 || bc !== 8) begin
        n_bad++;
        $display("FAIL timing[%0d]: got latency=%0d busy_cycles=%0d, expected 9 and 8", i, lat, bc);
      end
      if (i == 0) begin
        n_cmp++;
        if (bus8.busy !== 1'b0) begin
          n_bad++;
          $display("FAIL busy_in_done: got %b, expected 0", bus8.busy);
        end
        tick();
        n_cmp++;
        if (bus8.done !== 1'b0 || bus8.d !== 8'h02) begin
          n_bad++;
          $display("FAIL done_pulse: got done=%b d=%h, expected done=0 d=02", bus8.done, bus8.d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int e, held_bad;
    bus8.a = 8'h10;
    bus8.b = 8'h01;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    e = 1;
    tick();
    tick();
    e = 3;
    bus8.a = 8'hAA;
    bus8.start = 1'b1;
    tick();
    e++;
    n_cmp++;
    if (bus8.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_start_busy: got %b, expected 1", bus8.busy);
    end
    bus8.a = 8'h20;
    bus8.b = 8'h10;
    while (!bus8.done && e < 40) begin
      tick();
      e++;
    end
    n_cmp++;
    if (e !== 9 || bus8.d !== 8'h0F || bus8.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored_start_result: got latency=%0d d=%h busy=%b, expected 9 0f 0", e, bus8.d, bus8.busy);
    end
    tick();
    bus8.start = 1'b0;
    e = 1;
    n_cmp++;
    if (bus8.busy !== 1'b1 || bus8.d !== 8'h0F) begin
      n_bad++;
      $display("FAIL b2b_accept: got busy=%b d=%h, expected busy=1 d=0f", bus8.busy, bus8.d);
    end
    held_bad = 0;
    while (!bus8.done && e < 40) begin
      if (bus8.d !== 8'h0F) held_bad++;
      tick();
      e++;
    end
    n_cmp++;
    if (held_bad !== 0) begin
      n_bad++;
      $display("FAIL d_held_in_run: got %0d cycles with d changed, expected 0", held_bad);
    end
    n_cmp++;
    if (e !== 9 || {bus8.d, bus8.bout, bus8.ovf} !== {8'h10, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL b2b_result: got latency=%0d d=%h bout=%b ovf=%b, expected 9 10 0 0",
               e, bus8.d, bus8.bout, bus8.ovf);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    bus8.a = 8'h55;
    bus8.b = 8'h22;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus8.busy, bus8.done, bus8.d, bus8.bout, bus8.ovf} !== 12'h000) begin
      n_bad++;
      $display("FAIL async_reset: got busy=%b done=%b d=%h bout=%b ovf=%b, expected all 0",
               bus8.busy, bus8.done, bus8.d, bus8.bout, bus8.ovf);
    end
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus8.done || bus8.busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d cycles busy/done after reset, expected 0", seen);
    end
    run_op8(8'h09, 8'h04, lat, bc);
    n_cmp++;
    if (lat !== 9 || {bus8.d, bus8.bout, bus8.ovf} !== {8'h05, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL post_reset_op: got latency=%0d d=%h bout=%b ovf=%b, expected 9 05 0 0",
               lat, bus8.d, bus8.bout, bus8.ovf);
    end
  endtask

  task automatic test_random8();
    logic [7:0] a, b, ed;
    logic       eb, eo;
    int         lat, bc, bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      ed = a - b;
      eb = (a < b);
      eo = (a[7] != b[7]) && (ed[7] != a[7]);
      run_op8(a, b, lat, bc);
      if (lat !== 9 || {bus8.d, bus8.bout, bus8.ovf} !== {ed, eb, eo}) begin
        bad++;
        if (bad < 5)
          $display("FAIL random8 %h-%h: got d=%h bout=%b ovf=%b lat=%0d, expected d=%h bout=%b ovf=%b lat=9",
                   a, b, bus8.d, bus8.bout, bus8.ovf, lat, ed, eb, eo);
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL random8_total: got %0d bad ops, expected 0", bad);
    end
  endtask

  task automatic test_random16();
    logic [15:0] a, b, ed;
    logic        eb, eo;
    int          lat, bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a  = 16'($urandom);
      b  = (i < 4) ? {i[0], 15'h7FFF} : 16'($urandom);
      ed = a - b;
      eb = (a < b);
      eo = (a[15] != b[15]) && (ed[15] != a[15]);
      run_op16(a, b, lat);
      if (lat !== 17 || {bus16.d, bus16.bout, bus16.ovf} !== {ed, eb, eo}) begin
        bad++;
        if (bad < 5)
          $display("FAIL random16 %h-%h: got d=%h bout=%b ovf=%b lat=%0d, expected d=%h bout=%b ovf=%b lat=17",
                   a, b, bus16.d, bus16.bout, bus16.ovf, lat, ed, eb, eo);
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL random16_total: got %0d bad ops, expected 0", bad);
    end
  endtask

  initial begin
    bus8.start  = 1'b0;
    bus8.a      = 8'h00;
    bus8.b      = 8'h00;
    bus16.start = 1'b0;
    bus16.a     = 16'h0000;
    bus16.b     = 16'h0000;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
